fetch_predict_stage: RTL

FETCH_PREDICT_STAGE -- requirements
Module: fetch_predict_stage

---
 rtl/fetch_predict_stage_pkg.sv | 18 +
 rtl/fetch_predict_stage_branch_history_table.sv | 33 +++
 rtl/fetch_predict_stage.sv | 69 ++++++
 3 files changed

// File: rtl/fetch_predict_stage_pkg.sv
// Shared decode constants and helpers for the fetch/branch-predict stage.
package fetch_predict_stage_pkg;

  localparam logic [4:0]  OPCODE_BRANCH = 5'b11000;
  localparam logic [31:0] NOP_INST      = 32'h00000033;
  localparam int          BHT_DEPTH     = 16;
  localparam int          BHT_IDX_W     = 4;
  localparam logic [1:0]  CTR_RESET     = 2'b01;

  function automatic logic is_branch(input logic [6:0] opcode);
    return (opcode[6:2] == OPCODE_BRANCH) && (opcode[1:0] == 2'b11);
  endfunction

  function automatic logic [31:0] sext_b_imm(input logic [12:0] imm);
    return {{19{imm[12]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_predict_stage_branch_history_table.sv
// Table of 2-bit saturating counters; combinational read of the taken bit,
// registered update. A same-index read and write in one cycle returns the old value.
module branch_history_table
  import fetch_predict_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 wr_en,
  input  logic [BHT_IDX_W-1:0] wr_idx,
  input  logic                 taken
);

  logic [1:0] ctr [BHT_DEPTH];

  assign rd_taken = ctr[rd_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      if (taken && (ctr[wr_idx] != 2'b11)) begin
        ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
      end else if (!taken && (ctr[wr_idx] != 2'b00)) begin
        ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_predict_stage.sv
// Fetch PC generation with BHT-based branch prediction and the IF/ID register.
// One-cycle fetch-to-ID latency; stall holds PC and IF/ID, a mispredict flushes IF/ID.
module fetch_predict_stage
  import fetch_predict_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] imem_inst,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_pred_taken,
  output logic        mispredict
);

  logic        fetch_branch;
  logic        ctr_taken;
  logic        pred_taken;
  logic        resolve_ok;
  logic [12:0] b_imm;
  logic [31:0] pred_target;
  logic        unused_inst_bits;

  assign fetch_branch = is_branch(imem_inst[6:0]);
  assign pred_taken   = fetch_branch & ctr_taken;
  assign b_imm        = {imem_inst[31], imem_inst[7], imem_inst[30:25], imem_inst[11:8], 1'b0};
  assign pred_target  = pc_out + sext_b_imm(b_imm);

  // Register/funct fields play no part in prediction.
  assign unused_inst_bits = ^imem_inst[24:12];

  // A resolution arriving under stall is dropped entirely: no redirect, no training.
  assign resolve_ok = resolve_valid & ~stall;
  assign mispredict = resolve_ok & (resolve_taken != if_id_pred_taken);

  branch_history_table u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_out[BHT_IDX_W+1:2]),
    .rd_taken (ctr_taken),
    .wr_en    (resolve_ok),
    .wr_idx   (if_id_pc[BHT_IDX_W+1:2]),
    .taken    (resolve_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out           <= '0;
      if_id_pc         <= '0;
      if_id_inst       <= NOP_INST;
      if_id_pred_taken <= 1'b0;
    end else if (mispredict) begin
      pc_out           <= resolve_taken ? resolve_target : (if_id_pc + 32'd4);
      if_id_pc         <= '0;
      if_id_inst       <= NOP_INST;
      if_id_pred_taken <= 1'b0;
    end else if (!stall) begin
      pc_out           <= pred_taken ? pred_target : (pc_out + 32'd4);
      if_id_pc         <= pc_out;
      if_id_inst       <= imem_inst;
      if_id_pred_taken <= pred_taken;
    end
  end

endmodule
